ppu_tile_scheduler: RTL and testbench
=====================================

# ppu_tile_scheduler

Arbitrates between NUM_REQ accumulator-bank requesters and sequences one 16-beat partial-sum tile at a time into the post-processing unit (scale, bias, ReLU, truncation, quantize, approximate softmax). It sits between the systolic-array accumulator banks and the PPU. It latches the granted requester's FP8 scale and bias, streams the tile, and waits for the PPU completion pulse. It then returns the 128-bit softmax result to the requester through a valid/ready response port tagged with the requester ID.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8)
- ID_W, 1: width of resp_id; must satisfy 2^ID_W ≥ NUM_REQ
- TIMEOUT_CYCLES, 255: WAIT-state watchdog limit; only used with PPU_SCHED_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester tile request / beat valid
- req_ready  out  NUM_REQ  one-hot beat accept, granted requester only
- req_data  in  NUM_REQ*384  per-requester beat, 16×24-bit partial sums
- req_scale  in  NUM_REQ*8  per-requester FP8 E4M3 scale
- req_bias  in  NUM_REQ*8  per-requester bias
- ppu_valid  out  1  beat valid to PPU
- ppu_partial_sum  out  384  beat data to PPU
- ppu_scale  out  8  latched scale for the current tile
- ppu_bias  out  8  latched bias for the current tile
- ppu_done  in  1  PPU completion; level, held high after completion
- ppu_data  in  128  PPU softmax result
- resp_valid  out  1  result valid
- resp_ready  in  1  result accept
- resp_id  out  ID_W  requester index of the result
- resp_data  out  128  captured result
- busy  out  1  high in every state except IDLE
- protocol_err  out  1  sticky: granted requester dropped req_valid mid-tile
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE → ARB → STREAM → WAIT → RESP → IDLE.
- **IDLE:** when any req_valid is high, go to ARB.
- **ARB (1 cycle):**
  - Round-robin grant, searching from last_grant+1 with wrap.
  - Latch the granted index into grant, and latch ppu_scale and ppu_bias from that requester.
  - If no req_valid is high in this cycle, return to IDLE.
- **STREAM:**
  - req_ready[grant] is high for exactly 16 cycles; beat counter runs 0..15.
  - Each cycle, register req_data[grant] into ppu_partial_sum and assert ppu_valid.
  - The tile is contiguous. If req_valid[grant] is low on a beat, that beat is forwarded as zero, ppu_valid stays high, and protocol_err is set. protocol_err clears only on reset.
  - After beat 15, go to WAIT.
- **WAIT:**
  - Detect the rising edge of ppu_done (registered previous value). Level-high at WAIT entry does not count.
  - On the edge: capture ppu_data into resp_data, set resp_id to grant, go to RESP.
- **RESP:**
  - resp_valid stays high, and resp_id and resp_data stay stable, until resp_ready.
  - On handshake: last_grant ← grant, go to IDLE.
- **Round-robin:** last_grant resets to NUM_REQ-1, so requester 0 wins first after reset.
- **Reset (asynchronous, including mid-operation):**
  - State goes to IDLE; all outputs go to 0.
  - last_grant goes to NUM_REQ-1; the done-edge register goes to 0.
  - A tile interrupted by reset is dropped; no response is produced.

## Timing
- ARB is entered 1 cycle after req_valid is first seen in IDLE.
- req_ready asserts in the cycle after ARB.
- ppu_valid lags req_ready by 1 cycle (registered); the first beat reaches the PPU 3 cycles after the request.
- ppu_scale and ppu_bias are stable from the cycle after ARB until the next ARB.
- resp_valid asserts the cycle after the ppu_done rising edge is sampled.
- Minimum return from RESP to the next grant: 2 cycles (RESP handshake → IDLE → ARB).
- Only one tile is in flight at a time. New requests are ignored outside IDLE and ARB.
- A resp_ready held high continuously completes RESP in 1 cycle.

## Configuration
- PPU_SCHED_TIMEOUT_EN defined:
  - A WAIT counter clears on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without a ppu_done edge, timeout_err pulses for 1 cycle.
  - resp_data is forced to 0 and the block enters RESP with the current resp_id.
- PPU_SCHED_TIMEOUT_EN undefined:
  - WAIT waits indefinitely; timeout_err is tied to 0 and no counter is built.

## Test plan
- **Single tile:** reset; req_valid[0]=1, data beat k = all lanes k, scale 0x38, bias 0. Expect 16 ppu_valid beats carrying lane value k in order, ppu_scale=0x38. Pulse ppu_done with ppu_data=128'hA5..A5 → resp_valid with resp_id=0 and resp_data=A5..A5.
- **Round-robin:** req_valid[0] and req_valid[1] both held high for 3 tiles. Expect grant order 0,1,0 and resp_id order 0,1,0.
- **Done level:** ppu_done already high at WAIT entry. Expect no response until ppu_done falls and rises again.
- **Backpressure:** resp_ready low for 10 cycles. Expect resp_valid and resp_data stable, busy=1, no new req_ready; handshake on cycle 11, then IDLE.
- **Protocol error:** drop req_valid[1] on beat 7. Expect ppu_partial_sum=0 for that beat, still 16 ppu_valid beats, protocol_err=1 sticky.
- **Timeout / mid-operation reset:** with PPU_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, no ppu_done → timeout_err pulse, resp_data=0. Separately, assert rst_n low at beat 5 → all outputs 0, IDLE, next grant goes to requester 0.

Source files
------------

// File: rtl/ppu_tile_scheduler.sv
// rtl/ppu_tile_scheduler.sv - round-robin tile scheduler between accumulator banks and the PPU
// Optional WAIT watchdog: define PPU_SCHED_TIMEOUT_EN.
module ppu_tile_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*384-1:0]  req_data,
  input  logic [NUM_REQ*8-1:0]    req_scale,
  input  logic [NUM_REQ*8-1:0]    req_bias,
  output logic                    ppu_valid,
  output logic [383:0]            ppu_partial_sum,
  output logic [7:0]              ppu_scale,
  output logic [7:0]              ppu_bias,
  input  logic                    ppu_done,
  input  logic [127:0]            ppu_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [127:0]            resp_data,
  output logic                    busy,
  output logic                    protocol_err,
  output logic                    timeout_err
);

  if ((1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ppu_tile_scheduler: ID_W too narrow for NUM_REQ or TIMEOUT_CYCLES < 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_STREAM, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_found;
  logic [ID_W:0]   cand;
  logic [3:0]      beat_cnt;
  logic            done_q;
  logic            done_rise;
  logic            grant_valid;
  logic [383:0]    grant_data;

`ifdef PPU_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  assign done_rise   = ppu_done & ~done_q;
  assign grant_valid = req_valid[grant];
  assign grant_data  = req_data[int'(grant)*384 +: 384];

  // Round-robin: the first valid requester after last_grant, wrapping at NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!arb_found && req_valid[cand[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= ppu_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      grant           <= '0;
      last_grant      <= ID_W'(NUM_REQ - 1);
      beat_cnt        <= '0;
      req_ready       <= '0;
      ppu_valid       <= 1'b0;
      ppu_partial_sum <= '0;
      ppu_scale       <= '0;
      ppu_bias        <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= '0;
      resp_data       <= '0;
      busy            <= 1'b0;
      protocol_err    <= 1'b0;
`ifdef PPU_SCHED_TIMEOUT_EN
      wait_cnt        <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      ppu_valid <= 1'b0;
`ifdef PPU_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: if (|req_valid) begin
          state <= S_ARB;
          busy  <= 1'b1;
        end
        S_ARB: if (arb_found) begin
          grant     <= arb_idx;
          ppu_scale <= req_scale[int'(arb_idx)*8 +: 8];
          ppu_bias  <= req_bias[int'(arb_idx)*8 +: 8];
          req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
          beat_cnt  <= '0;
          state     <= S_STREAM;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        // A missing beat is forwarded as zero so the PPU always sees 16 beats.
        S_STREAM: begin
          ppu_valid       <= 1'b1;
          ppu_partial_sum <= grant_valid ? grant_data : '0;
          if (!grant_valid) protocol_err <= 1'b1;
          beat_cnt <= beat_cnt + 4'd1;
          if (beat_cnt == 4'd15) begin
            req_ready <= '0;
            state     <= S_WAIT;
`ifdef PPU_SCHED_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (done_rise) begin
            resp_data  <= ppu_data;
            resp_id    <= grant;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
`ifdef PPU_SCHED_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            resp_data   <= '0;
            resp_id     <= grant;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        S_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_tile_scheduler.sv
// tb/tb_ppu_tile_scheduler.sv - directed self-checking bench for ppu_tile_scheduler
module tb_ppu_tile_scheduler;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*384-1:0]  req_data = '0;
  logic [N*8-1:0]    req_scale = {8'h40, 8'h38};
  logic [N*8-1:0]    req_bias = {8'h05, 8'h00};
  logic              ppu_valid;
  logic [383:0]      ppu_partial_sum;
  logic [7:0]        ppu_scale;
  logic [7:0]        ppu_bias;
  logic              ppu_done = 1'b0;
  logic [127:0]      ppu_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [0:0]        resp_id;
  logic [127:0]      resp_data;
  logic              busy;
  logic              protocol_err;
  logic              timeout_err;

  int vectors = 0;
  int miscompares = 0;

  ppu_tile_scheduler #(.NUM_REQ(N), .ID_W(1), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_scale(req_scale), .req_bias(req_bias),
    .ppu_valid(ppu_valid), .ppu_partial_sum(ppu_partial_sum),
    .ppu_scale(ppu_scale), .ppu_bias(ppu_bias),
    .ppu_done(ppu_done), .ppu_data(ppu_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy), .protocol_err(protocol_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [383:0] beat_pat(input int r, input int k);
    logic [23:0] v;
    v = 24'(r * 256 + k);
    return {16{v}};
  endfunction

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] one;
    one = 1;
    return one << r;
  endfunction

  function automatic logic [7:0] scale_of(input int r);
    return (r == 0) ? 8'h38 : 8'h40;
  endfunction

  function automatic logic [7:0] bias_of(input int r);
    return (r == 0) ? 8'h00 : 8'h05;
  endfunction

  // One full tile from IDLE; r is the requester the round-robin must pick.
  task automatic do_tile(input int r, input int drop_beat, input bit done_early,
                         input int bp_cycles, input logic [127:0] result);
    tick();
    check("arb_busy", busy, 1);
    check("arb_no_ready", req_ready, 0);
    tick();
    check("grant_ready", req_ready, onehot(r));
    check("grant_scale", ppu_scale, scale_of(r));
    check("grant_bias", ppu_bias, bias_of(r));
    for (int k = 0; k < 16; k++) begin
      req_data[r*384 +: 384] = beat_pat(r, k);
      if (k == drop_beat) req_valid[r] = 1'b0;
      if (done_early && k == 10) ppu_done = 1'b1;
      tick();
      req_valid[r] = 1'b1;
      check("beat_valid", ppu_valid, 1);
      check("beat_data", ppu_partial_sum, (k == drop_beat) ? '0 : beat_pat(r, k));
      check("beat_ready", req_ready, (k < 15) ? onehot(r) : '0);
    end
    tick();
    check("wait_no_valid", ppu_valid, 0);
    check("wait_no_resp", resp_valid, 0);
    if (done_early) begin
      repeat (3) begin
        tick();
        check("level_no_resp", resp_valid, 0);
      end
      ppu_done = 1'b0;
      tick();
      check("fall_no_resp", resp_valid, 0);
    end
    ppu_data = result;
    ppu_done = 1'b1;
    tick();
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, r);
    check("resp_data", resp_data, result);
    ppu_data = ~result;
    for (int c = 0; c < bp_cycles; c++) begin
      tick();
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, result);
      check("bp_busy", busy, 1);
      check("bp_no_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    check("hs_valid_low", resp_valid, 0);
    check("hs_idle", busy, 0);
    resp_ready = 1'b0;
    ppu_done = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ppu_valid", ppu_valid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_protocol_err", protocol_err, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_scale", ppu_scale, 0);
    rst_n = 1'b1;

    // Single tile from requester 0.
    req_valid = 2'b01;
    do_tile(0, -1, 1'b0, 0, {16{8'hA5}});
    req_valid = 2'b00;
    tick();
    check("stay_idle", busy, 0);
    check("no_proto_err", protocol_err, 0);

    // Requester 1 drops req_valid on beat 7.
    req_valid = 2'b10;
    do_tile(1, 7, 1'b0, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    req_valid = 2'b00;
    check("proto_err_set", protocol_err, 1);

    // Both requesting: 0 (with backpressure), 1 (done already high), 0.
    req_valid = 2'b11;
    do_tile(0, -1, 1'b0, 10, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    do_tile(1, -1, 1'b1, 0, 128'hDEAD_BEEF_0000_0001_DEAD_BEEF_0000_0002);
    do_tile(0, -1, 1'b0, 0, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D);
    check("proto_err_sticky", protocol_err, 1);

    // Requester 1 would win next; reset it at beat 5.
    tick();
    tick();
    check("pre_rst_ready", req_ready, 2'b10);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", ppu_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_proto", protocol_err, 0);
    check("mid_rst_scale", ppu_scale, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_data", resp_data, 0);
    tick();
    rst_n = 1'b1;
    do_tile(0, -1, 1'b0, 0, 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A);

`ifdef PPU_SCHED_TIMEOUT_EN
    begin
      bit seen;
      req_valid = 2'b01;
      tick();
      tick();
      check("to_ready", req_ready, 2'b01);
      repeat (17) tick();
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (timeout_err) seen = 1'b1;
      end
      check("to_seen", seen, 1);
      check("to_resp_valid", resp_valid, 1);
      check("to_resp_data", resp_data, 0);
      check("to_resp_id", resp_id, 0);
      tick();
      check("to_pulse", timeout_err, 0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      req_valid = 2'b00;
      check("to_idle", busy, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
